// File: rtl/cla_bist_ctrl_if.sv
// Operand/result bus between the CLA BIST controller (master) and the adder under test (slave).
// The controller drives the operands and captures the sum and carry-out.
interface cla_bist_ctrl_if #(
    parameter int WIDTH = 4
) ();
    logic [WIDTH-1:0] a_out;
    logic [WIDTH-1:0] b_out;
    logic             cin_out;
    logic [WIDTH-1:0] s_in;
    logic             cout_in;

    modport master (
        output a_out,
        output b_out,
        output cin_out,
        input  s_in,
        input  cout_in
    );

    modport slave (
        input  a_out,
        input  b_out,
        input  cin_out,
        output s_in,
        output cout_in
    );
endinterface

// File: rtl/cla_bist_ctrl.sv
// Exhaustive self-test sequencer for a registered carry-lookahead adder: sweeps every {cin,B,A},
// checks each returned sum against a locally computed reference and reports pass/error count/first failure.
module cla_bist_ctrl #(
    parameter int WIDTH   = 4,
    parameter int LATENCY = 2,
    parameter int ERR_W   = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    cla_bist_ctrl_if.master      bus,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_W-1:0]     err_count,
    output logic [2*WIDTH:0]     first_fail_vec
);

    localparam int VW = 2 * WIDTH + 1;
    localparam int DW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [VW-1:0]    VEC_LAST   = {VW{1'b1}};
    localparam logic [DW-1:0]    DRAIN_LAST = DW'(LATENCY - 1);
    localparam logic [ERR_W-1:0] ERR_MAX    = {ERR_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic           valid;
        logic [WIDTH:0] exp;
        logic [VW-1:0]  vec;
    } pipe_t;

    // Reference result for a packed {cin,B,A} vector; MSB is the carry-out.
    function automatic logic [WIDTH:0] ref_sum(input logic [VW-1:0] v);
        return {1'b0, v[WIDTH-1:0]}
             + {1'b0, v[2*WIDTH-1:WIDTH]}
             + {{WIDTH{1'b0}}, v[VW-1]};
    endfunction

    state_e           state_q, state_d;
    logic [VW-1:0]    vec_q, vec_d;
    logic [VW-1:0]    op_q, op_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [VW-1:0]    ffv_q, ffv_d;
    pipe_t            pipe_q [LATENCY];
    pipe_t            pipe_d [LATENCY];
    pipe_t            tail_s;
    logic             mismatch_s;

    assign tail_s     = pipe_q[LATENCY-1];
    assign mismatch_s = tail_s.valid && ({bus.cout_in, bus.s_in} != tail_s.exp);

    // Sequencer, error accumulation and registered-output next values.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        op_d    = {VW{1'b0}};
        drain_d = drain_q;
        err_d   = err_q;
        ffv_d   = ffv_q;
        pass_d  = pass_q;

        if (mismatch_s) begin
            if (err_q != ERR_MAX) begin
                err_d = err_q + ERR_W'(1);
            end else begin
                err_d = err_q;
            end
            // A zero count means no earlier mismatch since the sweep began.
            if (err_q == {ERR_W{1'b0}}) begin
                ffv_d = tail_s.vec;
            end else begin
                ffv_d = ffv_q;
            end
        end else begin
            err_d = err_q;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_DRIVE;
                    vec_d   = {VW{1'b0}};
                    op_d    = {VW{1'b0}};
                    err_d   = {ERR_W{1'b0}};
                    ffv_d   = {VW{1'b0}};
                    pass_d  = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_DRIVE: begin
                if (vec_q == VEC_LAST) begin
                    state_d = ST_DRAIN;
                    drain_d = {DW{1'b0}};
                end else begin
                    vec_d = vec_q + VW'(1);
                    op_d  = vec_q + VW'(1);
                end
            end
            ST_DRAIN: begin
                // The last compare lands on this edge, so pass must see its update.
                if (drain_q == DRAIN_LAST) begin
                    state_d = ST_DONE;
                    pass_d  = (err_d == {ERR_W{1'b0}});
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_DRIVE) || (state_d == ST_DRAIN);
        done_d = (state_d == ST_DONE);
    end

    // Expected-result shift register aligned with the adder latency.
    always_comb begin
        pipe_d[0].valid = (state_q == ST_DRIVE);
        pipe_d[0].exp   = ref_sum(op_q);
        pipe_d[0].vec   = op_q;
        for (int i = 1; i < LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            vec_q   <= {VW{1'b0}};
            op_q    <= {VW{1'b0}};
            drain_q <= {DW{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= {ERR_W{1'b0}};
            ffv_q   <= {VW{1'b0}};
            for (int i = 0; i < LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            op_q    <= op_d;
            drain_q <= drain_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            ffv_q   <= ffv_d;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign bus.a_out      = op_q[WIDTH-1:0];
    assign bus.b_out      = op_q[2*WIDTH-1:WIDTH];
    assign bus.cin_out    = op_q[VW-1];
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign first_fail_vec = ffv_q;

endmodule

// File: tb/tb_cla_bist_ctrl.sv
// Bench for cla_bist_ctrl: a behavioural 4-bit registered adder with selectable latency and stuck faults,
// two controller instances (ERR_W=10 and ERR_W=4) sharing it, and a done-triggered scoreboard.
module tb_cla_bist_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic start;
    always #5 clk = ~clk;

    cla_bist_ctrl_if #(.WIDTH(4)) bus1 ();
    cla_bist_ctrl_if #(.WIDTH(4)) bus2 ();

    logic       busy1, done1, pass1;
    logic [9:0] err1;
    logic [8:0] ffv1;
    logic       busy2, done2, pass2;
    logic [3:0] err2;
    logic [8:0] ffv2;

    cla_bist_ctrl #(.WIDTH(4), .LATENCY(2), .ERR_W(10)) dut1 (
        .clk(clk), .rst(rst), .start(start), .bus(bus1),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .first_fail_vec(ffv1)
    );

    cla_bist_ctrl #(.WIDTH(4), .LATENCY(2), .ERR_W(4)) dut2 (
        .clk(clk), .rst(rst), .start(start), .bus(bus2),
        .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .first_fail_vec(ffv2)
    );

    // Behavioural adder: 2 or 3 register stages, optional stuck faults on the result.
    logic [4:0] m1, m2, m3, raw_s, mod_s;
    logic       lat3;
    logic [1:0] fault_mode;

    always_ff @(posedge clk) begin
        if (rst) begin
            m1 <= 5'd0;
            m2 <= 5'd0;
            m3 <= 5'd0;
        end else begin
            m1 <= {1'b0, bus1.a_out} + {1'b0, bus1.b_out} + {4'd0, bus1.cin_out};
            m2 <= m1;
            m3 <= m2;
        end
    end

    always_comb begin
        raw_s = lat3 ? m3 : m2;
        case (fault_mode)
            2'd1:    mod_s = raw_s & 5'b11101;
            2'd2:    mod_s = raw_s | 5'b10000;
            default: mod_s = raw_s;
        endcase
    end

    assign bus1.s_in    = mod_s[3:0];
    assign bus1.cout_in = mod_s[4];
    assign bus2.s_in    = mod_s[3:0];
    assign bus2.cout_in = mod_s[4];

    typedef struct {
        int busy_len;
        bit pass;
        bit err_any;
        int err;
        int ffv;
        int err2;
        bit pass2;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input longint act, input longint expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    function automatic exp_t mk(input int bl, input bit p, input bit any, input int e,
                                input int f, input int e2, input bit p2);
        exp_t r;
        r.busy_len = bl; r.pass = p; r.err_any = any; r.err = e;
        r.ffv = f; r.err2 = e2; r.pass2 = p2;
        return r;
    endfunction

    // Monitor: measures each busy window and checks results when done rises.
    initial begin
        int   cnt;
        bit   done_prev;
        exp_t e;
        cnt = 0;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (busy1) begin
                cnt++;
            end else begin
                if (done1 && !done_prev) begin
                    if (sbq.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_done: got done with empty scoreboard, expected none");
                    end else begin
                        e = sbq.pop_front();
                        chk("busy_len", cnt, e.busy_len);
                        chk("pass", pass1, e.pass);
                        if (e.err_any) chk("err_nonzero", (err1 != 10'd0), 1);
                        else           chk("err_count", err1, e.err);
                        chk("first_fail_vec", ffv1, e.ffv);
                        chk("err_count_w4", err2, e.err2);
                        chk("pass_w4", pass2, e.pass2);
                        chk("ffv_w4", ffv2, e.ffv);
                        chk("done_w4", done2, 1);
                        chk("busy_w4", busy2, 0);
                        chk("ops_idle", {bus1.cin_out, bus1.b_out, bus1.a_out}, 0);
                        chk("ops_idle_w4", {bus2.cin_out, bus2.b_out, bus2.a_out}, 0);
                    end
                end
                cnt = 0;
            end
            done_prev = done1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (!done1 && k < 3000) begin
            step();
            k++;
        end
        if (!done1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sweep_timeout: got done=0 after %0d cycles, expected done=1", k);
        end
    endtask

    // Start a sweep; optionally pulse start again mid-DRIVE and in the first DRAIN cycle.
    task automatic run_sweep(input exp_t e, input bit poke);
        sbq.push_back(e);
        pulse_start();
        if (poke) begin
            repeat (50) step();
            pulse_start();
            repeat (461) step();
            pulse_start();
        end
        wait_done();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        lat3       = 1'b0;
        fault_mode = 2'd0;
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy1, 0);
        chk("rst_done", done1, 0);
        chk("rst_pass", pass1, 0);
        chk("rst_err", err1, 0);
        chk("rst_ffv", ffv1, 0);
        chk("rst_ops", {bus1.cin_out, bus1.b_out, bus1.a_out}, 0);

        // Clean adder.
        run_sweep(mk(514, 1'b1, 1'b0, 0, 0, 0, 1'b1), 1'b0);
        // Sum bit1 stuck at 0: half of all vectors have bit1 set; first is A=2.
        fault_mode = 2'd1;
        run_sweep(mk(514, 1'b0, 1'b0, 256, 9'h002, 15, 1'b0), 1'b0);
        // Carry stuck at 1, started from DONE: 256 vectors have no carry; vector 0 is first.
        fault_mode = 2'd2;
        run_sweep(mk(514, 1'b0, 1'b0, 256, 9'h000, 15, 1'b0), 1'b0);
        // Clean again from DONE with start pulses during DRIVE and DRAIN.
        fault_mode = 2'd0;
        run_sweep(mk(514, 1'b1, 1'b0, 0, 0, 0, 1'b1), 1'b1);

        // Abort a faulty sweep with rst at DRIVE cycle 100.
        fault_mode = 2'd1;
        pulse_start();
        repeat (99) step();
        chk("busy_before_abort", busy1, 1);
        chk("err_before_abort", (err1 != 10'd0), 1);
        rst = 1'b1;
        step();
        chk("abort_busy", busy1, 0);
        chk("abort_done", done1, 0);
        chk("abort_pass", pass1, 0);
        chk("abort_err", err1, 0);
        chk("abort_ffv", ffv1, 0);
        chk("abort_ops", {bus1.cin_out, bus1.b_out, bus1.a_out}, 0);
        rst = 1'b0;
        fault_mode = 2'd0;
        repeat (3) step();
        run_sweep(mk(514, 1'b1, 1'b0, 0, 0, 0, 1'b1), 1'b0);

        // Adder one cycle slower than expected: vector 1 is compared against vector 0's sum.
        lat3 = 1'b1;
        run_sweep(mk(514, 1'b0, 1'b1, 0, 9'h001, 15, 1'b0), 1'b0);

        chk("scoreboard_drained", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
